dec_bpv_parser: RTL
===================

Name: dec_bpv_parser

Overview:
Sequential, parametrised block-prediction-vector (BPV) parser for BP-mode blocks. It accepts one block's suffix bitstream, then emits each BPV as a stream with a valid/ready handshake, walking NUM_SUBBLK sub-blocks that are each either 2x2 (one BPV) or 2x1 (two BPVs). When the block is finished it reports the total BPV bit count and the suffix left-aligned past the BPV field, ready for the coefficient/ECG decoder downstream.

Parameters:
SUFFIX_W, 128, width of the suffix window.
BPV_NUM_BITS, 6, BPV field width in non-FLS mode; legal range 2..7.
NUM_SUBBLK, 4, number of sub-blocks per block; legal range 1..8.
FLS_OFFSET, 32, value added to every BPV when isFls=1.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start_valid  in  1  block request
start_ready  out  1  high only in IDLE
mode_BP  in  1  block is BP mode; sampled at start handshake
isFls  in  1  first-line-slice flag; sampled at start handshake
use2x2_mask  in  NUM_SUBBLK  bit i=1: sub-block i is 2x2 (1 BPV); bit i=0: 2x1 (2 BPVs)
suffix  in  SUFFIX_W  bitstream, MSB first
bpv_valid  out  1  BPV available
bpv_ready  in  1  consumer accepts BPV
bpv_data  out  8  decoded BPV value
bpv_sub_idx  out  3  sub-block index of current BPV
bpv_part  out  1  0 = first/only BPV of the sub-block, 1 = second BPV of a 2x1 sub-block
bpv_last  out  1  current BPV is the last of the block
done  out  1  one-cycle pulse when the block completes
bpv_bits_total  out  8  total BPV bits consumed
suffix_rem  out  SUFFIX_W  suffix shifted left by bpv_bits_total

Behaviour:
- Reset: state IDLE. start_ready=1. bpv_valid, bpv_data, bpv_sub_idx, bpv_part, bpv_last, done, bpv_bits_total and suffix_rem are all 0.
- FSM states: IDLE, EXTRACT, DONE.
- IDLE -> on start_valid&start_ready:
  - Latch suffix into a shift register; latch mask and isFls; clear the bit counter; set sub_idx=0, part=0.
  - If mode_BP=1, go to EXTRACT. If mode_BP=0, go to DONE with total 0.
- bitsPerBpv = isFls ? BPV_NUM_BITS-1 : BPV_NUM_BITS, fixed for the whole block.
- EXTRACT:
  - bpv_valid=1 in every cycle spent in EXTRACT. The first BPV is valid in the cycle after the start handshake (latency 1).
  - bpv_data = zero-extended top bitsPerBpv bits of the shift register, plus FLS_OFFSET when isFls=1.
  - While bpv_ready=0, all outputs hold stable and nothing advances.
  - On bpv_valid&bpv_ready:
    - Shift the register left by bitsPerBpv (zero fill) and add bitsPerBpv to the counter.
    - Sequencing: if mask[sub_idx]=1 or part=1, then sub_idx+=1 and part=0; otherwise part=1.
  - bpv_last = (sub_idx==NUM_SUBBLK-1) && (mask[sub_idx] || part==1).
  - The handshake on bpv_last moves the FSM to DONE. Throughput is one BPV per cycle.
- DONE, held for one cycle:
  - done=1; bpv_bits_total = counter; suffix_rem = shift register.
  - Then return to IDLE.
  - bpv_bits_total and suffix_rem hold their values until the next start handshake.
- start_valid outside IDLE is ignored; requests are not queued.
- Width rule: the counter is 8 bits. The maximum is NUM_SUBBLK*2*BPV_NUM_BITS = 112, so it cannot overflow.
- bpv_data is 8 bits. The maximum value is (2^7-1)+FLS_OFFSET; any FLS_OFFSET up to 128 fits.
- rst asserted in any state returns the block to IDLE with all outputs at reset values on the next cycle. A partially emitted block is discarded.
- mask bits at or above NUM_SUBBLK do not exist; sub_idx never exceeds NUM_SUBBLK-1.

Test Plan:
- Defaults, isFls=0, mask=4'b1111, suffix[127:104]=000001_000010_000011_000100, bpv_ready=1 -> bpv_data 1,2,3,4 on consecutive cycles starting 1 cycle after start; bpv_last on 4th; done next cycle; bpv_bits_total=24; suffix_rem=suffix<<24.
- isFls=1, mask=4'b0000, suffix=all ones -> 8 BPVs, each 31+32=63; bpv_part alternates 0,1; bpv_sub_idx 0,0,1,1,2,2,3,3; bpv_bits_total=40.
- isFls=0, mask=4'b0101 -> 6 BPVs; bpv_sub_idx 0,1,1,2,3,3; bpv_part 0,0,1,0,0,1; bpv_bits_total=36.
- Backpressure: bpv_ready=0 for 3 cycles mid-block -> bpv_data, bpv_sub_idx and bpv_part stable throughout; no counter change; the sequence resumes unchanged when bpv_ready returns to 1.
- mode_BP=0 -> no bpv_valid; done 1 cycle after start; bpv_bits_total=0; suffix_rem=suffix.
- rst pulsed after 2 accepted BPVs -> next cycle bpv_valid=0, start_ready=1, bpv_bits_total=0; a new start then parses from the first BPV.

Source files
------------

// File: rtl/dec_bpv_parser.sv
// Block-prediction-vector parser for BP-mode blocks.
// Takes one block's suffix bitstream, streams out each BPV over a
// valid/ready handshake while walking the sub-blocks (2x2 -> one BPV,
// 2x1 -> two BPVs), then reports the BPV bit total and the suffix
// left-aligned past the BPV field for the downstream coefficient decoder.
module dec_bpv_parser #(
  parameter int SUFFIX_W     = 128,
  parameter int BPV_NUM_BITS = 6,
  parameter int NUM_SUBBLK   = 4,
  parameter int FLS_OFFSET   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic                  mode_BP,
  input  logic                  isFls,
  input  logic [NUM_SUBBLK-1:0] use2x2_mask,
  input  logic [SUFFIX_W-1:0]   suffix,
  output logic                  bpv_valid,
  input  logic                  bpv_ready,
  output logic [7:0]            bpv_data,
  output logic [2:0]            bpv_sub_idx,
  output logic                  bpv_part,
  output logic                  bpv_last,
  output logic                  done,
  output logic [7:0]            bpv_bits_total,
  output logic [SUFFIX_W-1:0]   suffix_rem
);

  typedef enum logic [1:0] {
    IDLE,
    EXTRACT,
    DONE
  } state_t;

  state_t              state;
  logic [SUFFIX_W-1:0] sr;        // suffix shift register, MSB = next bit
  logic [7:0]          cnt;       // BPV bits consumed so far
  logic [7:0]          mask_r;    // latched 2x2 mask, zero-padded to 8 sub-blocks
  logic                fls_r;     // latched first-line-slice flag
  logic [2:0]          sub_idx;
  logic                part;

  logic [3:0]          bpb;       // bits per BPV for the current block
  logic                adv_sub;   // current BPV closes its sub-block
  logic                last_c;    // current BPV closes the block
  logic                accept;    // BPV handshake this cycle
  logic                start_hs;  // block request accepted this cycle

  // Top bpb bits of the window, zero-extended, plus the FLS offset.
  // The top byte is taken and right-aligned so any width 1..8 works.
  function automatic logic [7:0] bpv_value(input logic [SUFFIX_W-1:0] win,
                                           input logic                fls,
                                           input logic [3:0]          width);
    logic [7:0] top;
    top = win[SUFFIX_W-1 -: 8] >> (4'd8 - width);
    return fls ? top + 8'(FLS_OFFSET) : top;
  endfunction

  assign bpb      = fls_r ? 4'(BPV_NUM_BITS - 1) : 4'(BPV_NUM_BITS);
  assign adv_sub  = mask_r[sub_idx] || part;
  assign last_c   = (sub_idx == 3'(NUM_SUBBLK - 1)) && adv_sub;
  assign accept   = bpv_valid && bpv_ready;
  assign start_hs = (state == IDLE) && start_valid && start_ready;

  // BPV-facing outputs are gated by valid so they read zero outside EXTRACT.
  assign bpv_data    = bpv_valid ? bpv_value(sr, fls_r, bpb) : 8'd0;
  assign bpv_sub_idx = bpv_valid ? sub_idx : 3'd0;
  assign bpv_part    = bpv_valid ? part : 1'b0;
  assign bpv_last    = bpv_valid ? last_c : 1'b0;

  // Suffix shift register: load on request, consume bpb bits per accepted BPV.
  always_ff @(posedge clk) begin
    if (start_hs) begin
      sr <= suffix;
    end else if ((state == EXTRACT) && accept) begin
      sr <= sr << bpb;
    end
  end

  // Control FSM with registered handshake, status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      start_ready    <= 1'b1;
      bpv_valid      <= 1'b0;
      done           <= 1'b0;
      bpv_bits_total <= 8'd0;
      suffix_rem     <= '0;
      cnt            <= 8'd0;
      mask_r         <= 8'd0;
      fls_r          <= 1'b0;
      sub_idx        <= 3'd0;
      part           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start_hs) begin
            mask_r      <= 8'(use2x2_mask);
            fls_r       <= isFls;
            cnt         <= 8'd0;
            sub_idx     <= 3'd0;
            part        <= 1'b0;
            start_ready <= 1'b0;
            if (mode_BP) begin
              state     <= EXTRACT;
              bpv_valid <= 1'b1;
            end else begin
              // Non-BP block: no BPV field, suffix passes through untouched.
              state          <= DONE;
              done           <= 1'b1;
              bpv_bits_total <= 8'd0;
              suffix_rem     <= suffix;
            end
          end
        end

        EXTRACT: begin
          if (accept) begin
            cnt <= cnt + 8'(bpb);
            if (last_c) begin
              // Publish results directly so they are visible in DONE.
              state          <= DONE;
              bpv_valid      <= 1'b0;
              done           <= 1'b1;
              bpv_bits_total <= cnt + 8'(bpb);
              suffix_rem     <= sr << bpb;
            end else if (adv_sub) begin
              sub_idx <= sub_idx + 3'd1;
              part    <= 1'b0;
            end else begin
              part <= 1'b1;
            end
          end
        end

        DONE: begin
          done        <= 1'b0;
          start_ready <= 1'b1;
          state       <= IDLE;
        end

        default: begin
          state       <= IDLE;
          start_ready <= 1'b1;
          bpv_valid   <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

endmodule
